uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL be a UART receiver: 8N1 frames, LSB first, 16x oversampling, no parameters.
REQ-002 clk  input  1  system clock; all logic on the rising edge.
REQ-003 rst  input  1  reset: synchronous, active-high.
REQ-004 baud_tick  input  1  one-clk-wide enable pulse at 16x the bit rate.
REQ-005 rx  input  1  asynchronous serial line; idles high.
REQ-006 data  output  8  last correctly framed byte.
REQ-007 valid  output  1  one-clk pulse: a new byte is on data.
REQ-008 frame_err  output  1  one-clk pulse: the stop bit was sampled low.
REQ-009 busy  output  1  high whenever the state is not IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer before any use; rx_s is the synchronized value.
REQ-011 States SHALL be IDLE, START, DATA and STOP, with a 4-bit tick counter cnt and a 3-bit bit index idx.
REQ-012 cnt SHALL advance only on baud_tick, wrap 15->0, and hold its value on clocks without baud_tick.
REQ-013 An armed flag SHALL set on any baud_tick where rx_s=1 in IDLE.
REQ-014 IDLE->START SHALL occur on a baud_tick with rx_s=0 and armed=1; that tick is cnt=0 and clears armed.
REQ-015 The sample point of each bit SHALL be the tick where cnt=7 (the "decision tick"; REQ-025 changes it).
REQ-016 START: rx_s=1 at the decision tick -> false start, return to IDLE, no output pulse.
REQ-017 START: otherwise, at cnt=15 -> DATA with idx=0.
REQ-018 DATA: on each decision tick, shift rx_s into a shift register at bit position idx.
REQ-019 DATA: at cnt=15, idx increments; at cnt=15 with idx=7 -> STOP.
REQ-020 STOP: on the decision tick the block SHALL return to IDLE immediately, giving a half-bit margin for the next start.
REQ-021 STOP, stop sample=1: data is loaded from the shift register and valid pulses.
REQ-022 STOP, stop sample=0: frame_err pulses, data is unchanged, armed stays clear until the line returns high.
REQ-023 valid and frame_err SHALL be registered, asserting on the clk after the decision tick; never both; each high for exactly 1 clk.
REQ-024 Latency SHALL be: valid rises 1 clk after the stop-bit decision tick, i.e. about 9.5 bit times after the start edge plus 3 clks (synchronizer and output register).

Reset
REQ-026 While rst=1 on a clock edge: state=IDLE, cnt=0, idx=0, armed=0, shift register=0x00, data=0x00, valid=0, frame_err=0, busy=0, synchronizer flops=1.
REQ-027 Reset SHALL override any in-flight frame; the partial byte is discarded with no pulse, and reception resumes only after rx_s is seen high (armed).

Configuration
REQ-025 Macro UART_RX_MAJORITY_EN defined: every bit value (start, data, stop) SHALL be the 2-of-3 majority of rx_s sampled on ticks cnt=6, 7 and 8, and the decision tick becomes cnt=8.
REQ-028 Macro UART_RX_MAJORITY_EN undefined: a single sample of rx_s at cnt=7 SHALL be used, and the majority logic SHALL not be present.

Verification
REQ-029 Byte 0xA5 sent with a valid stop bit, baud_tick every 4th clk -> exactly one valid pulse, data=0xA5, frame_err=0, busy low after the stop decision tick.
REQ-030 Byte 0x3C sent with the stop bit driven 0 -> one frame_err pulse, no valid, data stays 0xA5; no new frame until rx returns high.
REQ-031 rx low glitch lasting 4 ticks while idle -> START entered, false start at the decision tick, IDLE; valid=frame_err=0; a following 0x81 is received correctly.
REQ-032 rst pulsed for 1 clk during data bit 3 of 0x77 -> all outputs 0, no pulse; a subsequent clean 0x5A gives valid with data=0x5A.
REQ-033 Back-to-back 0x00 then 0xFF, each with a 16-tick stop bit -> two valid pulses carrying 0x00 then 0xFF, no frame_err.
REQ-034 0x00 with a 1-tick high glitch at cnt=7 of bit 2 -> data=0x00 with UART_RX_MAJORITY_EN defined; data=0x04 with it undefined.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, 16x oversampled by baud_tick.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting at ticks 6/7/8; default is a single sample at tick 7.
module uart_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] DEC_CNT = 4'd8;
`else
    localparam logic [3:0] DEC_CNT = 4'd7;
`endif
    localparam logic [3:0] LAST_CNT = 4'd15;
    localparam logic [2:0] LAST_IDX = 3'd7;

    logic       rx_meta;
    logic       rx_s;
    state_t     state;
    logic [3:0] cnt;
    logic [2:0] idx;
    logic       armed;
    logic [7:0] shreg;
    logic       bit_c;

    // Two-flop synchronizer; resets to the idle line level
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic s6;
    logic s7;

    // Early samples held for the vote taken at tick 8
    always_ff @(posedge clk) begin
        if (rst) begin
            s6 <= 1'b0;
            s7 <= 1'b0;
        end else if (baud_tick) begin
            if (cnt == 4'd6) s6 <= rx_s;
            if (cnt == 4'd7) s7 <= rx_s;
        end
    end

    assign bit_c = (s6 & s7) | (s6 & rx_s) | (s7 & rx_s);
`else
    assign bit_c = rx_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            idx       <= 3'd0;
            armed     <= 1'b0;
            shreg     <= 8'h00;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (baud_tick) begin
                case (state)
                    // A start edge only counts after the line has been seen high
                    IDLE: begin
                        cnt <= 4'd0;
                        if (rx_s) begin
                            armed <= 1'b1;
                        end else if (armed) begin
                            armed <= 1'b0;
                            state <= START;
                            busy  <= 1'b1;
                            cnt   <= 4'd1;
                        end
                    end
                    START: begin
                        if (cnt == DEC_CNT && bit_c) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            cnt   <= 4'd0;
                        end else begin
                            cnt <= cnt + 4'd1;
                            if (cnt == LAST_CNT) begin
                                state <= DATA;
                                idx   <= 3'd0;
                            end
                        end
                    end
                    DATA: begin
                        cnt <= cnt + 4'd1;
                        if (cnt == DEC_CNT) shreg[idx] <= bit_c;
                        if (cnt == LAST_CNT) begin
                            idx <= idx + 3'd1;
                            if (idx == LAST_IDX) state <= STOP;
                        end
                    end
                    // Leave at mid stop bit so the next start edge is not missed
                    STOP: begin
                        cnt <= cnt + 4'd1;
                        if (cnt == DEC_CNT) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            cnt   <= 4'd0;
                            if (bit_c) begin
                                data  <= shreg;
                                valid <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule
